axi_channel_fifo: RTL and testbench



---
 rtl/axi_channel_fifo.sv | 213 +++++++++++++++++++++
 tb/tb_axi_channel_fifo.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_channel_fifo.sv
// AXI4 channel buffer: one independent FIFO per channel (AW, W, B, AR, R).
// Depth=0 is a wire-through; FallThrough=1 lets an empty FIFO forward combinationally.

package axi_channel_fifo_pkg;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } aw_chan_t;

    typedef struct packed {
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
    } w_chan_t;

    typedef struct packed {
        logic [3:0] id;
        logic [1:0] resp;
    } b_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] addr;
        logic [7:0]  len;
    } ar_chan_t;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] data;
        logic [1:0]  resp;
        logic        last;
    } r_chan_t;

    typedef struct packed {
        aw_chan_t aw;
        logic     aw_valid;
        w_chan_t  w;
        logic     w_valid;
        logic     b_ready;
        ar_chan_t ar;
        logic     ar_valid;
        logic     r_ready;
    } axi_req_t;

    typedef struct packed {
        logic     aw_ready;
        logic     w_ready;
        b_chan_t  b;
        logic     b_valid;
        logic     ar_ready;
        r_chan_t  r;
        logic     r_valid;
    } axi_resp_t;

endpackage

module axi_channel_fifo_buf #(
    parameter int unsigned Depth       = 4,
    parameter bit          FallThrough = 1'b0,
    parameter type         data_t      = logic
) (
    input  logic  clk_i,
    input  logic  rst_ni,
    input  logic  in_valid,
    output logic  in_ready,
    input  data_t in_data,
    output logic  out_valid,
    input  logic  out_ready,
    output data_t out_data
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [PtrW-1:0] rd_ptr;
    logic [PtrW-1:0] wr_ptr;
    logic [CntW-1:0] count;
    data_t           mem [Depth];

    logic empty;
    logic full;
    logic bypass;
    logic do_push;
    logic do_pop;

    assign empty     = (count == '0);
    assign full      = (count == CntW'(Depth));
    // ready depends only on the registered count, never on out_ready
    assign in_ready  = !full;
    assign out_valid = !empty || (FallThrough && in_valid);
    assign out_data  = (FallThrough && empty) ? in_data : mem[rd_ptr];
    assign bypass    = FallThrough && empty && in_valid && out_ready;
    assign do_push   = in_valid && !full && !bypass;
    assign do_pop    = !empty && out_ready;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < Depth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= (wr_ptr == PtrW'(Depth - 1)) ? '0 : wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PtrW'(Depth - 1)) ? '0 : rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

module axi_channel_fifo #(
    parameter int unsigned Depth       = 4,
    parameter bit          FallThrough = 1'b0,
    parameter type         aw_chan_t   = axi_channel_fifo_pkg::aw_chan_t,
    parameter type         w_chan_t    = axi_channel_fifo_pkg::w_chan_t,
    parameter type         b_chan_t    = axi_channel_fifo_pkg::b_chan_t,
    parameter type         ar_chan_t   = axi_channel_fifo_pkg::ar_chan_t,
    parameter type         r_chan_t    = axi_channel_fifo_pkg::r_chan_t,
    parameter type         axi_req_t   = axi_channel_fifo_pkg::axi_req_t,
    parameter type         axi_resp_t  = axi_channel_fifo_pkg::axi_resp_t
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      test_i,
    input  axi_req_t  slv_req_i,
    output axi_resp_t slv_resp_o,
    output axi_req_t  mst_req_o,
    input  axi_resp_t mst_resp_i
);

    logic unused_test;
    assign unused_test = test_i;

    if (Depth == 0) begin : g_pass
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign mst_req_o  = slv_req_i;
        assign slv_resp_o = mst_resp_i;
    end else begin : g_fifo
        logic     aw_ready, aw_valid, w_ready, w_valid, ar_ready, ar_valid;
        logic     b_ready, b_valid, r_ready, r_valid;
        aw_chan_t aw;
        w_chan_t  w;
        b_chan_t  b;
        ar_chan_t ar;
        r_chan_t  r;

        axi_channel_fifo_buf #(.Depth(Depth), .FallThrough(FallThrough), .data_t(aw_chan_t)) u_aw (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(slv_req_i.aw_valid), .in_ready(aw_ready), .in_data(slv_req_i.aw),
            .out_valid(aw_valid), .out_ready(mst_resp_i.aw_ready), .out_data(aw)
        );

        axi_channel_fifo_buf #(.Depth(Depth), .FallThrough(FallThrough), .data_t(w_chan_t)) u_w (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(slv_req_i.w_valid), .in_ready(w_ready), .in_data(slv_req_i.w),
            .out_valid(w_valid), .out_ready(mst_resp_i.w_ready), .out_data(w)
        );

        axi_channel_fifo_buf #(.Depth(Depth), .FallThrough(FallThrough), .data_t(b_chan_t)) u_b (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(mst_resp_i.b_valid), .in_ready(b_ready), .in_data(mst_resp_i.b),
            .out_valid(b_valid), .out_ready(slv_req_i.b_ready), .out_data(b)
        );

        axi_channel_fifo_buf #(.Depth(Depth), .FallThrough(FallThrough), .data_t(ar_chan_t)) u_ar (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(slv_req_i.ar_valid), .in_ready(ar_ready), .in_data(slv_req_i.ar),
            .out_valid(ar_valid), .out_ready(mst_resp_i.ar_ready), .out_data(ar)
        );

        axi_channel_fifo_buf #(.Depth(Depth), .FallThrough(FallThrough), .data_t(r_chan_t)) u_r (
            .clk_i(clk_i), .rst_ni(rst_ni),
            .in_valid(mst_resp_i.r_valid), .in_ready(r_ready), .in_data(mst_resp_i.r),
            .out_valid(r_valid), .out_ready(slv_req_i.r_ready), .out_data(r)
        );

        always_comb begin
            mst_req_o          = '0;
            mst_req_o.aw       = aw;
            mst_req_o.aw_valid = aw_valid;
            mst_req_o.w        = w;
            mst_req_o.w_valid  = w_valid;
            mst_req_o.b_ready  = b_ready;
            mst_req_o.ar       = ar;
            mst_req_o.ar_valid = ar_valid;
            mst_req_o.r_ready  = r_ready;

            slv_resp_o          = '0;
            slv_resp_o.aw_ready = aw_ready;
            slv_resp_o.w_ready  = w_ready;
            slv_resp_o.b        = b;
            slv_resp_o.b_valid  = b_valid;
            slv_resp_o.ar_ready = ar_ready;
            slv_resp_o.r        = r;
            slv_resp_o.r_valid  = r_valid;
        end
    end

endmodule

// File: tb/tb_axi_channel_fifo.sv
// Scoreboard bench: three configurations (Depth 4, Depth 3 fall-through, Depth 0) share one stimulus.
module tb_axi_channel_fifo;
    import axi_channel_fifo_pkg::*;

    localparam int unsigned DA = 4;
    localparam int unsigned DB = 3;

    logic      clk;
    logic      rst_ni;
    axi_req_t  slv_req;
    axi_resp_t mst_resp;
    axi_req_t  mst_req_a, mst_req_b, mst_req_c;
    axi_resp_t slv_resp_a, slv_resp_b, slv_resp_c;

    int checks = 0;
    int errors = 0;
    logic [63:0] sbq [10][$];
    bit hs [5];

    axi_channel_fifo #(.Depth(DA), .FallThrough(1'b0),
        .aw_chan_t(aw_chan_t), .w_chan_t(w_chan_t), .b_chan_t(b_chan_t), .ar_chan_t(ar_chan_t),
        .r_chan_t(r_chan_t), .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_ni), .test_i(1'b0), .slv_req_i(slv_req), .slv_resp_o(slv_resp_a),
        .mst_req_o(mst_req_a), .mst_resp_i(mst_resp));

    axi_channel_fifo #(.Depth(DB), .FallThrough(1'b1),
        .aw_chan_t(aw_chan_t), .w_chan_t(w_chan_t), .b_chan_t(b_chan_t), .ar_chan_t(ar_chan_t),
        .r_chan_t(r_chan_t), .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t)) u_dut_b (
        .clk_i(clk), .rst_ni(rst_ni), .test_i(1'b0), .slv_req_i(slv_req), .slv_resp_o(slv_resp_b),
        .mst_req_o(mst_req_b), .mst_resp_i(mst_resp));

    axi_channel_fifo #(.Depth(0), .FallThrough(1'b0),
        .aw_chan_t(aw_chan_t), .w_chan_t(w_chan_t), .b_chan_t(b_chan_t), .ar_chan_t(ar_chan_t),
        .r_chan_t(r_chan_t), .axi_req_t(axi_req_t), .axi_resp_t(axi_resp_t)) u_dut_c (
        .clk_i(clk), .rst_ni(rst_ni), .test_i(1'b1), .slv_req_i(slv_req), .slv_resp_o(slv_resp_c),
        .mst_req_o(mst_req_c), .mst_resp_i(mst_resp));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(string name, logic [159:0] act, logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: a queue per channel; a beat enters on an accepted input
    // handshake and must leave, unmodified and in order, on an output handshake.
    task automatic sb(int unsigned q, int unsigned depth, bit ft, string name,
                      logic iv, logic ir, logic [63:0] ip, logic ov, logic orr, logic [63:0] op);
        int unsigned sz = sbq[q].size();
        check({name, "_ready"}, 160'(ir), 160'(sz < depth));
        check({name, "_valid"}, 160'(ov), 160'((sz > 0) || (ft && iv)));
        if (iv && ir) sbq[q].push_back(ip);
        if (ov && orr) begin
            if (sbq[q].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL %s_spurious: got beat %h expected none", name, op);
            end else begin
                check({name, "_data"}, 160'(op), 160'(sbq[q].pop_front()));
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        if (rst_ni) begin
            sb(0, DA, 0, "a_aw", slv_req.aw_valid, slv_resp_a.aw_ready, 64'(slv_req.aw),
               mst_req_a.aw_valid, mst_resp.aw_ready, 64'(mst_req_a.aw));
            sb(1, DA, 0, "a_w", slv_req.w_valid, slv_resp_a.w_ready, 64'(slv_req.w),
               mst_req_a.w_valid, mst_resp.w_ready, 64'(mst_req_a.w));
            sb(2, DA, 0, "a_b", mst_resp.b_valid, mst_req_a.b_ready, 64'(mst_resp.b),
               slv_resp_a.b_valid, slv_req.b_ready, 64'(slv_resp_a.b));
            sb(3, DA, 0, "a_ar", slv_req.ar_valid, slv_resp_a.ar_ready, 64'(slv_req.ar),
               mst_req_a.ar_valid, mst_resp.ar_ready, 64'(mst_req_a.ar));
            sb(4, DA, 0, "a_r", mst_resp.r_valid, mst_req_a.r_ready, 64'(mst_resp.r),
               slv_resp_a.r_valid, slv_req.r_ready, 64'(slv_resp_a.r));
            sb(5, DB, 1, "b_aw", slv_req.aw_valid, slv_resp_b.aw_ready, 64'(slv_req.aw),
               mst_req_b.aw_valid, mst_resp.aw_ready, 64'(mst_req_b.aw));
            sb(6, DB, 1, "b_w", slv_req.w_valid, slv_resp_b.w_ready, 64'(slv_req.w),
               mst_req_b.w_valid, mst_resp.w_ready, 64'(mst_req_b.w));
            sb(7, DB, 1, "b_b", mst_resp.b_valid, mst_req_b.b_ready, 64'(mst_resp.b),
               slv_resp_b.b_valid, slv_req.b_ready, 64'(slv_resp_b.b));
            sb(8, DB, 1, "b_ar", slv_req.ar_valid, slv_resp_b.ar_ready, 64'(slv_req.ar),
               mst_req_b.ar_valid, mst_resp.ar_ready, 64'(mst_req_b.ar));
            sb(9, DB, 1, "b_r", mst_resp.r_valid, mst_req_b.r_ready, 64'(mst_resp.r),
               slv_resp_b.r_valid, slv_req.r_ready, 64'(slv_resp_b.r));
            hs[0] = slv_req.aw_valid && slv_resp_a.aw_ready;
            hs[1] = slv_req.w_valid  && slv_resp_a.w_ready;
            hs[2] = mst_resp.b_valid && mst_req_a.b_ready;
            hs[3] = slv_req.ar_valid && slv_resp_a.ar_ready;
            hs[4] = mst_resp.r_valid && mst_req_a.r_ready;
            check("d0_req",  160'(mst_req_c),  160'(slv_req));
            check("d0_resp", 160'(slv_resp_c), 160'(mst_resp));
        end
    end

    task automatic set_idle();
        slv_req           = '0;
        slv_req.b_ready   = 1'b1;
        slv_req.r_ready   = 1'b1;
        mst_resp          = '0;
        mst_resp.aw_ready = 1'b1;
        mst_resp.w_ready  = 1'b1;
        mst_resp.ar_ready = 1'b1;
    endtask

    task automatic idle(int n);
        @(posedge clk);
        #1 set_idle();
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    // Valids are held until the Depth-4 instance accepts them, then re-rolled.
    task automatic rand_cycles(int n);
        logic [63:0] rv;
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            if (!slv_req.aw_valid || hs[0]) begin
                rv = rnd64(); slv_req.aw = rv[$bits(aw_chan_t)-1:0]; slv_req.aw_valid = 1'($urandom_range(0, 1));
            end
            if (!slv_req.w_valid || hs[1]) begin
                rv = rnd64(); slv_req.w = rv[$bits(w_chan_t)-1:0]; slv_req.w_valid = 1'($urandom_range(0, 1));
            end
            if (!mst_resp.b_valid || hs[2]) begin
                rv = rnd64(); mst_resp.b = rv[$bits(b_chan_t)-1:0]; mst_resp.b_valid = 1'($urandom_range(0, 1));
            end
            if (!slv_req.ar_valid || hs[3]) begin
                rv = rnd64(); slv_req.ar = rv[$bits(ar_chan_t)-1:0]; slv_req.ar_valid = 1'($urandom_range(0, 1));
            end
            if (!mst_resp.r_valid || hs[4]) begin
                rv = rnd64(); mst_resp.r = rv[$bits(r_chan_t)-1:0]; mst_resp.r_valid = 1'($urandom_range(0, 1));
            end
            mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
            mst_resp.w_ready  = ($urandom_range(0, 2) != 0);
            mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
            slv_req.b_ready   = ($urandom_range(0, 2) != 0);
            slv_req.r_ready   = ($urandom_range(0, 3) != 0);
        end
    endtask

    task automatic check_reset();
        axi_req_t  exp_req;
        axi_resp_t exp_resp;
        exp_req           = '0;
        exp_req.b_ready   = 1'b1;
        exp_req.r_ready   = 1'b1;
        exp_resp          = '0;
        exp_resp.aw_ready = 1'b1;
        exp_resp.w_ready  = 1'b1;
        exp_resp.ar_ready = 1'b1;
        check("rst_req_a",  160'(mst_req_a),  160'(exp_req));
        check("rst_resp_a", 160'(slv_resp_a), 160'(exp_resp));
        check("rst_req_b",  160'(mst_req_b),  160'(exp_req));
        check("rst_resp_b", 160'(slv_resp_b), 160'(exp_resp));
    endtask

    initial begin
        rst_ni = 1'b0;
        set_idle();
        #2 check_reset();
        repeat (2) @(posedge clk);
        #2 rst_ni = 1'b1;

        // Latency: AW id=3 addr=0x1000 appears one cycle after its push
        idle(6);
        slv_req.aw_valid  = 1'b1;
        slv_req.aw.id     = 4'd3;
        slv_req.aw.addr   = 32'h1000;
        mst_resp.aw_ready = 1'b0;
        @(negedge clk);
        check("lat_accept", 160'(slv_resp_a.aw_ready), 160'(1));
        check("lat_early",  160'(mst_req_a.aw_valid),  160'(0));
        @(posedge clk);
        #1 slv_req.aw_valid = 1'b0;
        @(negedge clk);
        check("lat_valid", 160'(mst_req_a.aw_valid), 160'(1));
        check("lat_id",    160'(mst_req_a.aw.id),    160'(3));
        check("lat_addr",  160'(mst_req_a.aw.addr),  160'(32'h1000));
        @(posedge clk);
        #1 mst_resp.aw_ready = 1'b1;
        @(posedge clk);
        #1 check("lat_popped", 160'(mst_req_a.aw_valid), 160'(0));

        // Full: W stalled downstream, five beats offered
        idle(6);
        mst_resp.w_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            slv_req.w_valid = 1'b1;
            slv_req.w.data  = 32'hA0 + 32'(i);
            @(negedge clk);
            check("full_ready", 160'(slv_resp_a.w_ready), 160'(i < 4));
            if (i < 4) begin
                @(posedge clk);
                #1;
            end
        end
        @(posedge clk);
        #1 mst_resp.w_ready = 1'b1;
        @(negedge clk);
        check("full_no_comb", 160'(slv_resp_a.w_ready), 160'(0));
        check("full_head0",   160'(mst_req_a.w.data),   160'(32'hA0));
        @(posedge clk);
        #1;
        @(negedge clk);
        check("full_reopen", 160'(slv_resp_a.w_ready), 160'(1));
        check("full_head1",  160'(mst_req_a.w.data),   160'(32'hA1));

        // Fall-through on the Depth-3 instance: R 0x55 forwarded in the same cycle
        idle(6);
        mst_resp.r_valid = 1'b1;
        mst_resp.r.data  = 32'h55;
        @(negedge clk);
        check("ft_valid",    160'(slv_resp_b.r_valid), 160'(1));
        check("ft_data",     160'(slv_resp_b.r.data),  160'(32'h55));
        check("ft_nft_wait", 160'(slv_resp_a.r_valid), 160'(0));
        @(posedge clk);
        #1 mst_resp.r_valid = 1'b0;
        @(negedge clk);
        check("ft_not_stored", 160'(slv_resp_b.r_valid), 160'(0));

        // Independence: B stalled with one beat held while AR streams every cycle
        idle(6);
        slv_req.b_ready  = 1'b0;
        mst_resp.b_valid = 1'b1;
        mst_resp.b.id    = 4'd5;
        mst_resp.b.resp  = 2'd2;
        for (int k = 0; k < 10; k++) begin
            slv_req.ar_valid = 1'b1;
            slv_req.ar.addr  = 32'h2000 + 32'(16 * k);
            @(negedge clk);
            check("ind_ar_ready", 160'(slv_resp_a.ar_ready), 160'(1));
            if (k > 0) begin
                check("ind_ar_addr", 160'(mst_req_a.ar.addr), 160'(32'h2000 + 32'(16 * (k - 1))));
                check("ind_b_held",  160'({slv_resp_a.b_valid, slv_resp_a.b}), 160'({1'b1, 4'd5, 2'd2}));
            end
            @(posedge clk);
            #1 mst_resp.b_valid = 1'b0;
        end

        rand_cycles(1500);

        // Asynchronous reset in the middle of traffic
        @(posedge clk);
        #3 rst_ni = 1'b0;
        set_idle();
        #1 check_reset();
        foreach (sbq[i]) sbq[i].delete();
        @(posedge clk);
        #2 rst_ni = 1'b1;
        @(posedge clk);
        #1;
        slv_req.aw_valid = 1'b1;
        slv_req.aw.id    = 4'd7;
        slv_req.aw.addr  = 32'h40;
        @(negedge clk);
        check("post_rst_accept", 160'(slv_resp_a.aw_ready), 160'(1));
        @(posedge clk);
        #1 slv_req.aw_valid = 1'b0;
        @(negedge clk);
        check("post_rst_out", 160'({mst_req_a.aw_valid, mst_req_a.aw.addr}), 160'({1'b1, 32'h40}));

        rand_cycles(1500);
        idle(10);
        @(negedge clk);
        foreach (sbq[i]) check($sformatf("drain_q%0d", i), 160'(sbq[i].size()), 160'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
